muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers for the multicycle MIPS datapath. It extends the combinational ALU with MULT/MULTU/DIV/DIVU and MTHI/MTLO support, parametrised in data width. It uses a start/busy/done handshake so the controller can stall mfhi/mflo until the result is ready. One radix-2 step is computed per cycle.

Parameters:
WIDTH, 32, operand and HI/LO width (even, >= 4)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  request an operation; sampled only in IDLE
op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
a  input  WIDTH  multiplicand / dividend (rs)
b  input  WIDTH  multiplier / divisor (rt)
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
wd  input  WIDTH  MTHI/MTLO write data
busy  output  1  high while an operation is in progress (state != IDLE)
done  output  1  one-cycle pulse when HI/LO have been updated
div_by_zero  output  1  valid with done; divide with b == 0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (asynchronous, any time, including mid-operation): state=IDLE, counter=0, hi=0, lo=0, done=0, div_by_zero=0, busy=0. No partial result is retained.
- FSM states: IDLE, CALC, FIX.
- IDLE: if start=1 at an edge, latch op, capture operand magnitudes and operand signs, counter<=0, go to CALC. For signed ops, magnitude = two's-complement absolute value taken as unsigned WIDTH bits; the most-negative value maps to 2^(WIDTH-1).
- CALC: one shift-add (multiply) or restoring-subtract (divide) step per cycle, WIDTH steps in total. At the edge where counter==WIDTH-1, go to FIX.
- FIX: apply sign correction, write hi/lo, done<=1, div_by_zero<=(divide && b==0), go to IDLE.
- Latency: start sampled at edge E0 -> busy high after E0 -> hi/lo updated and done high after edge E0+WIDTH+1. done lasts exactly one cycle; busy is low in that same cycle.
- Multiply: the 2*WIDTH-bit product goes to {hi,lo}. MULT negates the full 2*WIDTH product when the operand signs differ.
- Divide: lo=quotient, hi=remainder. DIV negates the quotient when the operand signs differ; the remainder takes the dividend's sign.
  - Most-negative / -1 gives lo=most-negative, hi=0; no exception.
- Divide by zero: the operation still runs the full latency. Result is lo=all ones, hi=a (original dividend, unsigned and signed alike), div_by_zero=1 with done.
- div_by_zero is cleared at the next edge, together with done.
- start while busy: ignored; no queueing.
- hi_we/lo_we: write wd to hi/lo at the edge only when in IDLE; ignored while busy.
  - hi_we and lo_we together write both registers.
  - hi_we/lo_we and start in the same IDLE cycle: the write takes effect, then the operation starts and its result later overwrites both registers.
- Operand inputs a/b/op need only be valid in the start cycle; changes afterwards have no effect.
- hi/lo are held stable during CALC; they change only via a FIX write, an MTHI/MTLO write, or reset.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF start at E0 -> done after E0+33, hi=0xFFFFFFFE lo=0x00000001; busy high for 33 cycles.
- MULT a=-3 (0xFFFFFFFD) b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1. Then DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0x00000000, div_by_zero=0. DIVU a=7 b=0 -> lo=0xFFFFFFFF hi=0x00000007, div_by_zero=1 for exactly one cycle.
- MTHI wd=0x1234 then MTLO wd=0x5678 while idle -> hi=0x1234 lo=0x5678. Same writes asserted while busy -> no change; the pending result lands intact.
- Second start with different operands 5 cycles into a DIVU 100/7 -> ignored; result lo=14 hi=2; exactly one done pulse.
- Assert reset 10 cycles into a MULTU -> busy, done, hi, lo all 0 immediately (asynchronously). A fresh MULTU 6*7 after release -> lo=42 hi=0 after WIDTH+1 cycles.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit with architectural HI/LO registers
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   start, op           request an operation (00 MULTU, 01 MULT, 10 DIVU, 11 DIV); sampled in IDLE
//   a, b                multiplicand/dividend and multiplier/divisor, valid in the start cycle
//   hi_we, lo_we, wd    MTHI/MTLO writes, honoured only in IDLE
//   busy, done          operation in progress; one-cycle pulse when HI/LO were updated
//   div_by_zero         valid with done; divide with b == 0
//   hi, lo              HI/LO registers
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t             state;
    logic [1:0]         op_q;
    logic               sa, sb;
    logic [WIDTH-1:0]   ma, mb;
    // Multiply: {partial product high, multiplier shifting out}; divide: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mag_a, mag_b, quo, rem, a_orig;
    logic [WIDTH:0]     mul_t, rem_sh, diff;
    logic [2*WIDTH-1:0] mul_next, div_next, prod;
    logic               neg;

    assign busy = state != IDLE;

    always_comb begin
        mag_a    = (op[0] && a[WIDTH-1]) ? -a : a;
        mag_b    = (op[0] && b[WIDTH-1]) ? -b : b;
        mul_t    = acc[0] ? {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, ma} : {1'b0, acc[2*WIDTH-1:WIDTH]};
        mul_next = {mul_t, acc[WIDTH-1:1]};
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        diff     = rem_sh - {1'b0, mb};
        // A borrow in diff[WIDTH] means the trial subtraction failed: keep the shifted remainder
        div_next = {diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0], acc[WIDTH-2:0], ~diff[WIDTH]};
        neg      = op_q[0] && (sa ^ sb);
        prod     = neg ? -acc : acc;
        quo      = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem      = (op_q[0] && sa) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        // sa is only set for signed ops, so this recovers the original dividend in both cases
        a_orig   = sa ? -ma : ma;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            op_q        <= '0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            ma          <= '0;
            mb          <= '0;
            acc         <= '0;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wd;
                    if (lo_we) lo <= wd;
                    if (start) begin
                        op_q  <= op;
                        sa    <= op[0] && a[WIDTH-1];
                        sb    <= op[0] && b[WIDTH-1];
                        ma    <= mag_a;
                        mb    <= mag_b;
                        acc   <= {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= op_q[1] ? div_next : mul_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) state <= FIX;
                end
                FIX: begin
                    done        <= 1'b1;
                    div_by_zero <= op_q[1] && mb == '0;
                    {hi, lo}    <= !op_q[1] ? prod : mb == '0 ? {a_orig, {WIDTH{1'b1}}} : {rem, quo};
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking scoreboard bench for muldiv_unit
module tb_muldiv_unit;
    localparam int W = 32;
    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } res_t;

    logic clk = 0, reset = 1, start = 0, hi_we = 0, lo_we = 0;
    logic [1:0] op = 0;
    logic [W-1:0] a = 0, b = 0, wd = 0;
    logic busy, done, div_by_zero;
    logic [W-1:0] hi, lo;
    int checks = 0, fails = 0;
    res_t sb[$];

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wd(wd), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    function automatic res_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        res_t r;
        logic [2*W-1:0] p;
        r = '0;
        case (o)
            2'd0: begin p = {{W{1'b0}}, x} * {{W{1'b0}}, y}; {r.hi, r.lo} = p; end
            2'd1: begin p = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y}); {r.hi, r.lo} = p; end
            default: begin
                if (y == 0) begin
                    r.hi = x; r.lo = '1; r.dbz = 1'b1;
                end else if (o == 2'd2) begin
                    r.lo = x / y; r.hi = x % y;
                end else if (x == {1'b1, {(W-1){1'b0}}} && y == '1) begin
                    r.lo = x; r.hi = '0;
                end else begin
                    r.lo = $signed(x) / $signed(y); r.hi = $signed(x) % $signed(y);
                end
            end
        endcase
        return r;
    endfunction

    task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
        op = o; a = x; b = y; start = 1;
        if (push) sb.push_back(model(o, x, y));
        @(negedge clk);
        start = 0; op = 2'($urandom); a = $urandom; b = $urandom;
    endtask

    task automatic wait_done(output bit ok, output int bc);
        ok = 0; bc = 0;
        for (int i = 0; i < 4 * W; i++) begin
            if (done) begin ok = 1; break; end
            if (busy) bc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 0) begin fails++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (done !== 0) begin fails++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (div_by_zero !== 0) begin fails++; $display("FAIL reset_dbz got %0b want 0", div_by_zero); end
        checks++; if ({hi, lo} !== '0) begin fails++; $display("FAIL reset_hilo got %h_%h want 0", hi, lo); end
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_multu_max;
        bit ok; int bc; res_t e;
        launch(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        wait_done(ok, bc);
        e = sb.size() ? sb.pop_front() : '0;
        checks++; if (!ok) begin fails++; $display("FAIL multu_max_timeout got no done want done"); end
        checks++; if (bc !== W + 1) begin fails++; $display("FAIL multu_max_busy got %0d want %0d", bc, W + 1); end
        checks++; if (hi !== 32'hFFFF_FFFE || hi !== e.hi) begin fails++; $display("FAIL multu_max_hi got %h want fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001 || lo !== e.lo) begin fails++; $display("FAIL multu_max_lo got %h want 00000001", lo); end
        checks++; if (busy !== 0) begin fails++; $display("FAIL multu_max_busy_at_done got %0b want 0", busy); end
        @(negedge clk);
        checks++; if (done !== 0) begin fails++; $display("FAIL multu_max_done_pulse got %0b want 0", done); end
    endtask

    task automatic test_signed;
        logic [1:0] ops [2] = '{2'd1, 2'd3};
        logic [W-1:0] xs [2] = '{32'hFFFF_FFFD, 32'hFFFF_FFF9};
        logic [W-1:0] ys [2] = '{32'd5, 32'd2};
        logic [W-1:0] ehi [2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [W-1:0] elo [2] = '{32'hFFFF_FFF1, 32'hFFFF_FFFD};
        bit ok; int bc; res_t e;
        for (int i = 0; i < 2; i++) begin
            launch(ops[i], xs[i], ys[i], 1);
            wait_done(ok, bc);
            e = sb.size() ? sb.pop_front() : '0;
            checks++; if (!ok) begin fails++; $display("FAIL signed%0d_timeout got no done want done", i); end
            checks++; if (hi !== ehi[i] || hi !== e.hi) begin fails++; $display("FAIL signed%0d_hi got %h want %h", i, hi, ehi[i]); end
            checks++; if (lo !== elo[i] || lo !== e.lo) begin fails++; $display("FAIL signed%0d_lo got %h want %h", i, lo, elo[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_div_edge;
        bit ok; int bc; res_t e;
        launch(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        wait_done(ok, bc);
        e = sb.size() ? sb.pop_front() : '0;
        checks++; if (!ok) begin fails++; $display("FAIL divmin_timeout got no done want done"); end
        checks++; if ({hi, lo, div_by_zero} !== {32'h0, 32'h8000_0000, 1'b0} || {hi, lo, div_by_zero} !== e) begin
            fails++; $display("FAIL divmin got %h_%h_%0b want 00000000_80000000_0", hi, lo, div_by_zero); end
        @(negedge clk);
        launch(2'd2, 32'd7, 32'd0, 1);
        wait_done(ok, bc);
        e = sb.size() ? sb.pop_front() : '0;
        checks++; if (!ok) begin fails++; $display("FAIL divzero_timeout got no done want done"); end
        checks++; if (bc !== W + 1) begin fails++; $display("FAIL divzero_latency got %0d want %0d", bc, W + 1); end
        checks++; if ({hi, lo, div_by_zero} !== {32'd7, 32'hFFFF_FFFF, 1'b1} || {hi, lo, div_by_zero} !== e) begin
            fails++; $display("FAIL divzero got %h_%h_%0b want 00000007_ffffffff_1", hi, lo, div_by_zero); end
        @(negedge clk);
        checks++; if (div_by_zero !== 0 || done !== 0) begin fails++; $display("FAIL divzero_pulse got dbz=%0b done=%0b want 0 0", div_by_zero, done); end
        launch(2'd3, 32'hFFFF_FFF0, 32'd0, 1);
        wait_done(ok, bc);
        e = sb.size() ? sb.pop_front() : '0;
        checks++; if ({hi, lo, div_by_zero} !== {32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1} || {hi, lo, div_by_zero} !== e) begin
            fails++; $display("FAIL divzero_signed got %h_%h_%0b want fffffff0_ffffffff_1", hi, lo, div_by_zero); end
        @(negedge clk);
    endtask

    task automatic test_mthi_mtlo;
        hi_we = 1; wd = 32'h1234;
        @(negedge clk);
        hi_we = 0; lo_we = 1; wd = 32'h5678;
        @(negedge clk);
        lo_we = 0;
        checks++; if (hi !== 32'h1234) begin fails++; $display("FAIL mthi got %h want 00001234", hi); end
        checks++; if (lo !== 32'h5678) begin fails++; $display("FAIL mtlo got %h want 00005678", lo); end
    endtask

    task automatic test_busy_write;
        bit ok; int bc; res_t e;
        launch(2'd0, 32'h0001_0000, 32'h0001_0000, 1);
        hi_we = 1; lo_we = 1; wd = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        hi_we = 0; lo_we = 0;
        checks++; if (hi !== 32'h1234 || lo !== 32'h5678) begin fails++; $display("FAIL busy_write_hold got %h_%h want 00001234_00005678", hi, lo); end
        wait_done(ok, bc);
        e = sb.size() ? sb.pop_front() : '0;
        checks++; if (!ok) begin fails++; $display("FAIL busy_write_timeout got no done want done"); end
        checks++; if ({hi, lo} !== {32'd1, 32'd0} || {hi, lo} !== {e.hi, e.lo}) begin fails++; $display("FAIL busy_write_result got %h_%h want 00000001_00000000", hi, lo); end
        @(negedge clk);
    endtask

    task automatic test_random;
        bit ok; int bc; res_t e;
        logic [W-1:0] x, y;
        logic [1:0] o;
        for (int i = 0; i < 12; i++) begin
            o = 2'(i % 4); x = $urandom; y = (i == 5) ? 32'd3 : $urandom;
            if (i >= 8) y = y >> (i * 3);
            launch(o, x, y, 1);
            wait_done(ok, bc);
            e = sb.size() ? sb.pop_front() : '0;
            checks++; if (!ok || {hi, lo, div_by_zero} !== e) begin
                fails++; $display("FAIL random%0d op=%0d a=%h b=%h got %h_%h_%0b want %h_%h_%0b", i, o, x, y, hi, lo, div_by_zero, e.hi, e.lo, e.dbz); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back_ignored;
        bit ok; int bc; int extra; res_t e;
        launch(2'd2, 32'd100, 32'd7, 1);
        repeat (4) @(negedge clk);
        op = 2'd0; a = 32'd3; b = 32'd9; start = 1;
        @(negedge clk);
        start = 0;
        wait_done(ok, bc);
        e = sb.size() ? sb.pop_front() : '0;
        checks++; if (!ok) begin fails++; $display("FAIL ignored_timeout got no done want done"); end
        checks++; if ({hi, lo} !== {32'd2, 32'd14} || {hi, lo} !== {e.hi, e.lo}) begin fails++; $display("FAIL ignored_result got %h_%h want 00000002_0000000e", hi, lo); end
        extra = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        checks++; if (extra !== 0) begin fails++; $display("FAIL ignored_single_done got %0d extra active cycles want 0", extra); end
    endtask

    task automatic test_async_reset;
        bit ok; int bc; res_t e;
        launch(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        repeat (9) @(negedge clk);
        reset = 1;
        #1;
        checks++; if (busy !== 0 || done !== 0) begin fails++; $display("FAIL async_reset_ctrl got busy=%0b done=%0b want 0 0", busy, done); end
        checks++; if ({hi, lo} !== '0) begin fails++; $display("FAIL async_reset_hilo got %h_%h want 0", hi, lo); end
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        launch(2'd0, 32'd6, 32'd7, 1);
        wait_done(ok, bc);
        e = sb.size() ? sb.pop_front() : '0;
        checks++; if (!ok || bc !== W + 1) begin fails++; $display("FAIL post_reset_latency got ok=%0b busy=%0d want 1 %0d", ok, bc, W + 1); end
        checks++; if ({hi, lo} !== {32'd0, 32'd42} || {hi, lo} !== {e.hi, e.lo}) begin fails++; $display("FAIL post_reset_mul got %h_%h want 00000000_0000002a", hi, lo); end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_multu_max;
        test_signed;
        test_div_edge;
        test_mthi_mtlo;
        test_busy_write;
        test_random;
        test_back_to_back_ignored;
        test_async_reset;
        checks++; if (sb.size() != 0) begin fails++; $display("FAIL scoreboard_left got %0d entries want 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
